lcplc_input_sequencer: RTL and testbench
========================================

# lcplc_input_sequencer

Front-end controller for the LCPLC coder. It accepts a per-frame geometry configuration and a flat stream of raw samples, already ordered block by block, band by band and row by row. It forwards each sample to the coder's x port with the four framing flags x_last_r, x_last_s, x_last_b and x_last_i generated from internal counters. It sits between the sample source (DMA/reader) and LCPLC, and LCPLC needs no knowledge of image dimensions.

## Interface
- DATA_WIDTH, 16, sample width.
- DIM_WIDTH, 12, width of row/column counts (max 4095).
- BAND_WIDTH, 10, width of band count (max 1023).
- BLOCK_SIZE_LOG, 4, spatial block edge is B = 2^BLOCK_SIZE_LOG (16x16 = 256 samples, matches MAX_SLICE_SIZE_LOG 8).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration handshake valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_rows  in  DIM_WIDTH  image rows, 1..max.
- cfg_cols  in  DIM_WIDTH  image columns, 1..max.
- cfg_bands  in  BAND_WIDTH  image bands, 1..max.
- cfg_error  out  1  one-cycle pulse when a config with a zero field is consumed.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample ready.
- in_data  in  DATA_WIDTH  sample.
- x_valid  out  1  to LCPLC.
- x_ready  in  1  from LCPLC.
- x_data  out  DATA_WIDTH  registered sample.
- x_last_r  out  1  last sample of a block row.
- x_last_s  out  1  last sample of a slice (one band of one block).
- x_last_b  out  1  last sample of last band of a block.
- x_last_i  out  1  last sample of the image.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse after the x_last_i beat is accepted.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - cfg_ready=1, in_ready=0.
  - A cfg handshake with every field nonzero latches rows, cols and bands, clears all counters and goes to RUN.
  - A cfg handshake with any zero field: pulse cfg_error, stay in IDLE.
- **Stream order:**
  - Blocks in raster order over the block grid.
  - Within each block, bands 0..bands-1.
  - Within each band, block rows, then columns.
- **Edge blocks:**
  - Block width w = min(B, cols - bx*B).
  - Block height h = min(B, rows - by*B).
  - Track remaining columns/rows as decrementing registers; no multiplier.
- **Counters:**
  - c (column in block), r (row in block), b (band).
  - bx, by (block indices), or their equivalent remaining-count registers.
  - All counters advance only on an input handshake (in_valid && in_ready).
- **Flags computed for the accepted beat:**
  - last_r = (c == w-1).
  - last_s = last_r && (r == h-1).
  - last_b = last_s && (b == bands-1).
  - last_i = last_b && last block column && last block row.
- **Output register:** a single stage. in_ready = (state == RUN) && (!x_valid || x_ready). On an input handshake, x_data and the flags load and x_valid goes to 1. Otherwise, when x_ready is high, x_valid goes to 0.
- **Leaving RUN:** accepting the input beat with last_i set moves RUN to DRAIN, and in_ready drops the following cycle.
- **DRAIN:** when the x_last_i beat completes (x_valid && x_ready), pulse frame_done and return to IDLE.
- **Config outside IDLE:** a cfg request in RUN or DRAIN is not consumed (cfg_ready=0) and is held by the source.

## Timing
- **Reset values:** state=IDLE, x_valid=0, x_data=0, all x_last_*=0, busy=0, frame_done=0, cfg_error=0. in_ready=0 and cfg_ready=1 (both combinational from state).
- **Latency:** 1 cycle from input handshake to x_valid.
- **Throughput:** with x_ready held high, 1 sample per cycle sustained.
- **Ready paths:** in_ready depends combinationally on x_ready; no other combinational in→out paths.
- **Backpressure:** x_valid, x_data and flags are stable while x_valid && !x_ready.
- **Simultaneous events:** an output drain and a new input load in the same cycle are legal; x_valid stays 1.
- **cfg_error:** asserted the cycle after the rejected config handshake.
- **frame_done:** asserted the cycle after the final output handshake; cfg_ready is 1 in that same cycle.
- **Reset mid-frame:** asserting rst clears all state immediately, including any in-flight beat, which is dropped. The next frame requires a new cfg.

## Test plan
- **Full block, two bands:**
  - Setup: BLOCK_SIZE_LOG=2, cfg 4x4x2, samples 0..31, x_ready=1.
  - Data: 32 beats out equal to the input.
  - x_last_r at beats 3,7,…,31.
  - x_last_s at beats 15 and 31.
  - x_last_b and x_last_i at beat 31 only.
  - frame_done one cycle after beat 31.
- **Partial edge blocks:**
  - Setup: BLOCK_SIZE_LOG=2, cfg rows=5, cols=6, bands=1, 30 samples.
  - x_last_r at beats 3,7,11,15,17,19,21,23,27,29.
  - x_last_s and x_last_b at beats 15,23,27,29.
  - x_last_i at beat 29.
- **Backpressure:**
  - Stimulus: same as scenario 1 with x_ready random 50% and in_valid random 50%.
  - Output sequence and flags identical to scenario 1.
  - in_ready=0 whenever x_valid && !x_ready.
  - Outputs stable while stalled.
- **Config while running:**
  - Stimulus: cfg_valid held high from beat 5 of a frame.
  - cfg_ready=0 until the frame_done cycle.
  - The second config is consumed then, and the next frame's first beat has counters at zero.
- **Illegal config:**
  - Stimulus: cfg bands=0.
  - cfg_error pulses once, busy stays 0, in_ready stays 0.
  - A following valid cfg 4x4x1 runs normally.
- **Reset mid-frame:**
  - Stimulus: assert rst for 1 cycle during beat 10 of scenario 1.
  - All outputs return to reset values asynchronously.
  - After a new cfg, the frame restarts with flags at the same positions as scenario 1.

Source files
------------

// File: rtl/lcplc_input_sequencer.sv
// Input sequencer for LCPLC: turns a flat sample stream into coder beats
// tagged with row/slice/block/image framing flags from internal counters.
//
// Ports:
//   clk, rst (async, active-low)
//   cfg_valid/cfg_ready, cfg_rows, cfg_cols, cfg_bands, cfg_error
//   in_valid/in_ready, in_data      : raw samples from source
//   x_valid/x_ready, x_data,
//   x_last_r/s/b/i                  : registered beats to LCPLC
//   busy, frame_done                : status
module lcplc_input_sequencer #(
   parameter int DATA_WIDTH     = 16,
   parameter int DIM_WIDTH      = 12,
   parameter int BAND_WIDTH     = 10,
   parameter int BLOCK_SIZE_LOG = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [DIM_WIDTH-1:0]  cfg_rows,
   input  logic [DIM_WIDTH-1:0]  cfg_cols,
   input  logic [BAND_WIDTH-1:0] cfg_bands,
   output logic                  cfg_error,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  x_valid,
   input  logic                  x_ready,
   output logic [DATA_WIDTH-1:0] x_data,
   output logic                  x_last_r,
   output logic                  x_last_s,
   output logic                  x_last_b,
   output logic                  x_last_i,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int BL = BLOCK_SIZE_LOG;
   localparam int PAD = DIM_WIDTH - BL;

   localparam logic [DIM_WIDTH-1:0] BLK =
      DIM_WIDTH'(1 << BL);
   localparam logic [DIM_WIDTH-1:0] BLK_M1 =
      DIM_WIDTH'((1 << BL) - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_e;

   state_e state_q, state_d;

   logic [DIM_WIDTH-1:0]  cols_q, cols_d;
   logic [BAND_WIDTH-1:0] bands_m1_q, bands_m1_d;

   // Remaining columns/rows from the current block origin to the
   // image edge; replaces bx*B / by*B arithmetic.
   logic [DIM_WIDTH-1:0]  cols_rem_q, cols_rem_d;
   logic [DIM_WIDTH-1:0]  rows_rem_q, rows_rem_d;

   logic [BL-1:0]         c_q, c_d;
   logic [BL-1:0]         r_q, r_d;
   logic [BAND_WIDTH-1:0] b_q, b_d;

   logic                  x_valid_q, x_valid_d;
   logic [DATA_WIDTH-1:0] x_data_q, x_data_d;
   logic                  x_last_r_q, x_last_r_d;
   logic                  x_last_s_q, x_last_s_d;
   logic                  x_last_b_q, x_last_b_d;
   logic                  x_last_i_q, x_last_i_d;
   logic                  cfg_error_q, cfg_error_d;
   logic                  frame_done_q, frame_done_d;

   logic                  col_last_blk;
   logic                  row_last_blk;
   logic [DIM_WIDTH-1:0]  w_m1;
   logic [DIM_WIDTH-1:0]  h_m1;
   logic [DIM_WIDTH-1:0]  c_ext;
   logic [DIM_WIDTH-1:0]  r_ext;
   logic                  last_r;
   logic                  last_s;
   logic                  last_b;
   logic                  last_i;
   logic                  in_hs;
   logic                  out_hs;
   logic                  cfg_hs;
   logic                  cfg_bad;

   assign cfg_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign in_ready  = (state_q == S_RUN) &&
                      (!x_valid_q || x_ready);

   assign in_hs  = in_valid && in_ready;
   assign out_hs = x_valid_q && x_ready;
   assign cfg_hs = cfg_valid && cfg_ready;

   assign cfg_bad = (cfg_rows == '0) ||
                    (cfg_cols == '0) ||
                    (cfg_bands == '0);

   // Edge blocks are narrower/shorter when less than B remains.
   assign col_last_blk = (cols_rem_q <= BLK);
   assign row_last_blk = (rows_rem_q <= BLK);

   assign w_m1 = col_last_blk ?
                 cols_rem_q - 1'b1 : BLK_M1;
   assign h_m1 = row_last_blk ?
                 rows_rem_q - 1'b1 : BLK_M1;

   assign c_ext = {{PAD{1'b0}}, c_q};
   assign r_ext = {{PAD{1'b0}}, r_q};

   assign last_r = (c_ext == w_m1);
   assign last_s = last_r && (r_ext == h_m1);
   assign last_b = last_s && (b_q == bands_m1_q);
   assign last_i = last_b && col_last_blk &&
                   row_last_blk;

   always_comb begin
      state_d      = state_q;
      cols_d       = cols_q;
      bands_m1_d   = bands_m1_q;
      cols_rem_d   = cols_rem_q;
      rows_rem_d   = rows_rem_q;
      c_d          = c_q;
      r_d          = r_q;
      b_d          = b_q;
      x_valid_d    = x_valid_q;
      x_data_d     = x_data_q;
      x_last_r_d   = x_last_r_q;
      x_last_s_d   = x_last_s_q;
      x_last_b_d   = x_last_b_q;
      x_last_i_d   = x_last_i_q;
      cfg_error_d  = 1'b0;
      frame_done_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cfg_hs) begin
               if (cfg_bad) begin
                  cfg_error_d = 1'b1;
               end else begin
                  cols_d     = cfg_cols;
                  bands_m1_d = cfg_bands - 1'b1;
                  cols_rem_d = cfg_cols;
                  rows_rem_d = cfg_rows;
                  c_d        = '0;
                  r_d        = '0;
                  b_d        = '0;
                  state_d    = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (in_hs && last_i) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_hs) begin
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Nested counter carry: column -> row -> band -> block.
      if (in_hs) begin
         if (!last_r) begin
            c_d = c_q + 1'b1;
         end else begin
            c_d = '0;
            if (!last_s) begin
               r_d = r_q + 1'b1;
            end else begin
               r_d = '0;
               if (!last_b) begin
                  b_d = b_q + 1'b1;
               end else begin
                  b_d = '0;
                  if (!col_last_blk) begin
                     cols_rem_d = cols_rem_q - BLK;
                  end else begin
                     cols_rem_d = cols_q;
                     if (!row_last_blk) begin
                        rows_rem_d = rows_rem_q - BLK;
                     end
                  end
               end
            end
         end
      end

      if (in_hs) begin
         x_valid_d  = 1'b1;
         x_data_d   = in_data;
         x_last_r_d = last_r;
         x_last_s_d = last_s;
         x_last_b_d = last_b;
         x_last_i_d = last_i;
      end else if (x_ready) begin
         x_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cols_q       <= '0;
         bands_m1_q   <= '0;
         cols_rem_q   <= '0;
         rows_rem_q   <= '0;
         c_q          <= '0;
         r_q          <= '0;
         b_q          <= '0;
         x_valid_q    <= 1'b0;
         x_data_q     <= '0;
         x_last_r_q   <= 1'b0;
         x_last_s_q   <= 1'b0;
         x_last_b_q   <= 1'b0;
         x_last_i_q   <= 1'b0;
         cfg_error_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cols_q       <= cols_d;
         bands_m1_q   <= bands_m1_d;
         cols_rem_q   <= cols_rem_d;
         rows_rem_q   <= rows_rem_d;
         c_q          <= c_d;
         r_q          <= r_d;
         b_q          <= b_d;
         x_valid_q    <= x_valid_d;
         x_data_q     <= x_data_d;
         x_last_r_q   <= x_last_r_d;
         x_last_s_q   <= x_last_s_d;
         x_last_b_q   <= x_last_b_d;
         x_last_i_q   <= x_last_i_d;
         cfg_error_q  <= cfg_error_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign x_valid    = x_valid_q;
   assign x_data     = x_data_q;
   assign x_last_r   = x_last_r_q;
   assign x_last_s   = x_last_s_q;
   assign x_last_b   = x_last_b_q;
   assign x_last_i   = x_last_i_q;
   assign cfg_error  = cfg_error_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcplc_input_sequencer.sv
// Directed bench for lcplc_input_sequencer with B=4 blocks.
// Drives at negedge, samples at negedge+1, expected flags as bit masks.
module tb_lcplc_input_sequencer;

   localparam int DW  = 16;
   localparam int DMW = 12;
   localparam int BW  = 10;
   localparam int BSL = 2;

   logic           clk;
   logic           rst;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [DMW-1:0] cfg_rows;
   logic [DMW-1:0] cfg_cols;
   logic [BW-1:0]  cfg_bands;
   logic           cfg_error;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  in_data;
   logic           x_valid;
   logic           x_ready;
   logic [DW-1:0]  x_data;
   logic           x_last_r;
   logic           x_last_s;
   logic           x_last_b;
   logic           x_last_i;
   logic           busy;
   logic           frame_done;

   int checks   = 0;
   int failures = 0;

   lcplc_input_sequencer #(
      .DATA_WIDTH     (DW),
      .DIM_WIDTH      (DMW),
      .BAND_WIDTH     (BW),
      .BLOCK_SIZE_LOG (BSL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_rows   (cfg_rows),
      .cfg_cols   (cfg_cols),
      .cfg_bands  (cfg_bands),
      .cfg_error  (cfg_error),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .x_valid    (x_valid),
      .x_ready    (x_ready),
      .x_data     (x_data),
      .x_last_r   (x_last_r),
      .x_last_s   (x_last_s),
      .x_last_b   (x_last_b),
      .x_last_i   (x_last_i),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 4x4x2: row ends every 4th beat, slices end at 15 and 31.
   localparam logic [31:0] S1_R = 32'h8888_8888;
   localparam logic [31:0] S1_S = 32'h8000_8000;
   localparam logic [31:0] S1_I = 32'h8000_0000;
   // 5x6x1 with B=4: edge blocks 2 wide and 1 tall.
   localparam logic [31:0] S2_R = 32'h28AA_8888;
   localparam logic [31:0] S2_S = 32'h2880_8000;
   localparam logic [31:0] S2_I = 32'h2000_0000;
   // 4x4x1: one slice of 16 beats.
   localparam logic [31:0] S4_R = 32'h0000_8888;
   localparam logic [31:0] S4_S = 32'h0000_8000;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic send_cfg(input int rows,
                           input int cols,
                           input int bands,
                           input bit bad);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_rows  = DMW'(rows);
      cfg_cols  = DMW'(cols);
      cfg_bands = BW'(bands);
      #1;
      chk("cfg_ready_idle", cfg_ready, 1);
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("cfg_error", cfg_error, bad);
      chk("busy_after_cfg", busy, !bad);
      chk("in_ready_after_cfg", in_ready, !bad);
      if (bad) begin
         @(negedge clk);
         chk("cfg_error_once", cfg_error, 0);
         chk("busy_stays_0", busy, 0);
         chk("in_ready_stays_0", in_ready, 0);
      end
   endtask

   task automatic run_frame(input string tag,
                            input int n,
                            input logic [31:0] mr,
                            input logic [31:0] ms,
                            input logic [31:0] mb,
                            input logic [31:0] mi,
                            input bit rnd,
                            input int abort_at,
                            input int cfg_at);
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      bit fd_exp  = 0;
      bit stalled = 0;
      bit fin     = 0;
      logic [DW-1:0] hd;
      logic [3:0]    hf;
      hd = '0;
      hf = '0;
      while (!fin && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         chk({tag, "_frame_done"}, frame_done, fd_exp);
         if (cfg_valid)
            chk({tag, "_cfg_ready_held"}, cfg_ready, fd_exp);
         if (fd_exp) begin
            chk({tag, "_cfg_ready_done"}, cfg_ready, 1);
            fin = 1;
         end else if (abort_at > 0 && sent == abort_at) begin
            in_valid = 1'b0;
            fin = 1;
         end else begin
            if (stalled) begin
               chk({tag, "_stall_valid"}, x_valid, 1);
               chk({tag, "_stall_data"}, x_data, hd);
               chk({tag, "_stall_flags"},
                   {x_last_r, x_last_s, x_last_b, x_last_i},
                   hf);
            end
            if (cfg_at > 0 && sent == cfg_at) begin
               cfg_valid = 1'b1;
               cfg_rows  = 12'd4;
               cfg_cols  = 12'd4;
               cfg_bands = 10'd2;
            end
            in_valid = (sent < n) &&
                       (!rnd || $urandom_range(0, 1) == 1);
            in_data  = DW'(sent);
            x_ready  = !rnd || $urandom_range(0, 1) == 1;
            #1;
            if (x_valid && !x_ready)
               chk({tag, "_in_ready_stall"}, in_ready, 0);
            if (sent == n)
               chk({tag, "_in_ready_drain"}, in_ready, 0);
            if (x_valid && x_ready) begin
               chk({tag, "_data"}, x_data, DW'(got));
               chk({tag, "_flags"},
                   {x_last_r, x_last_s, x_last_b, x_last_i},
                   {mr[got], ms[got], mb[got], mi[got]});
               got++;
               if (got == n) fd_exp = 1;
            end
            stalled = x_valid && !x_ready;
            hd = x_data;
            hf = {x_last_r, x_last_s, x_last_b, x_last_i};
            if (in_valid && in_ready) sent++;
         end
      end
      in_valid = 1'b0;
      chk({tag, "_completed_in_budget"}, fin, 1);
   endtask

   initial begin
      rst       = 1'b0;
      cfg_valid = 1'b0;
      cfg_rows  = '0;
      cfg_cols  = '0;
      cfg_bands = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      x_ready   = 1'b1;
      #3;
      chk("rst_x_valid", x_valid, 0);
      chk("rst_x_data", x_data, 0);
      chk("rst_flags",
          {x_last_r, x_last_s, x_last_b, x_last_i}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_cfg_error", cfg_error, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cfg_ready", cfg_ready, 1);
      @(negedge clk);
      rst = 1'b1;

      // full block, two bands
      send_cfg(4, 4, 2, 0);
      run_frame("s1", 32, S1_R, S1_S, S1_I, S1_I, 0, 0, 0);

      // partial edge blocks
      send_cfg(5, 6, 1, 0);
      run_frame("s2", 30, S2_R, S2_S, S2_S, S2_I, 0, 0, 0);

      // random backpressure and input gaps
      send_cfg(4, 4, 2, 0);
      run_frame("s3", 32, S1_R, S1_S, S1_I, S1_I, 1, 0, 0);

      // config held from beat 5, consumed at frame_done
      send_cfg(4, 4, 1, 0);
      run_frame("s4a", 16, S4_R, S4_S, S4_S, S4_S, 0, 0, 5);
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("s4_second_cfg_taken", busy, 1);
      run_frame("s4b", 32, S1_R, S1_S, S1_I, S1_I, 0, 0, 0);

      // illegal config then a legal one
      send_cfg(4, 4, 0, 1);
      send_cfg(4, 4, 1, 0);
      run_frame("s5", 16, S4_R, S4_S, S4_S, S4_S, 0, 0, 0);

      // reset mid-frame with beat 10 in flight
      send_cfg(4, 4, 2, 0);
      run_frame("s6a", 32, S1_R, S1_S, S1_I, S1_I, 0, 11, 0);
      chk("s6_inflight", x_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("s6_rst_x_valid", x_valid, 0);
      chk("s6_rst_x_data", x_data, 0);
      chk("s6_rst_flags",
          {x_last_r, x_last_s, x_last_b, x_last_i}, 0);
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_in_ready", in_ready, 0);
      chk("s6_rst_cfg_ready", cfg_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("s6_idle_after_rst", busy, 0);
      send_cfg(4, 4, 2, 0);
      run_frame("s6b", 32, S1_R, S1_S, S1_I, S1_I, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
